// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: pipeline write-back (A) vs long-latency unit (B).
// Registered write stage with starvation guard for B and a read bypass for decode.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_reg,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic        reg_write,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]  cnt;
    logic        force_b;
    logic        grant_a;
    logic        grant_b;
    logic        grant;
    logic [4:0]  g_reg;
    logic [31:0] g_data;

    // Arbitration: A wins by default, B is forced through once starved
    always_comb begin
        force_b = b_valid && (cnt == LIMIT);
        a_ready = !force_b;
        b_ready = b_valid && (!a_valid || force_b);
        grant_a = a_valid && a_ready;
        grant_b = b_valid && b_ready;
        grant   = grant_a || grant_b;
        g_reg   = grant_b ? b_reg : a_reg;
        g_data  = grant_b ? b_data : a_data;
    end

    // Starvation counter: counts refused B cycles, saturating at the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (!b_valid || grant_b) begin
            cnt <= 4'd0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 4'd1;
        end
    end

    // Output stage: register the winning write; r0 writes are swallowed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
        end else begin
            reg_write <= 1'b0;
            if (grant && (g_reg != 5'd0)) begin
                reg_write  <= 1'b1;
                write_reg  <= g_reg;
                write_data <= g_data;
            end
        end
    end

    // Bypass: serve the pending write until the register file captures it
    always_comb begin
        fwd_data1 = rf_data1;
        fwd_data2 = rf_data2;
        if (reg_write && (write_reg == read_reg1) && (read_reg1 != 5'd0))
            fwd_data1 = write_data;
        if (reg_write && (write_reg == read_reg2) && (read_reg2 != 5'd0))
            fwd_data2 = write_data;
    end

endmodule
